// File: rtl/func_gen_pkg.sv
// func_gen_pkg: shared definitions for the DDS function generator.
//   - fg_func_e : waveform select codes (3'b111 is an alias of DC)
//   - LFSR_SEED / LFSR_TAPS : 16-bit Galois LFSR noise source
//   - lfsr_next : one right-shift step of that LFSR
`timescale 1ns/1ps
package func_gen_pkg;

  typedef enum logic [2:0] {
    FG_SQUARE = 3'd0,
    FG_SINE   = 3'd1,
    FG_TRI    = 3'd2,
    FG_SAW    = 3'd3,
    FG_RSAW   = 3'd4,
    FG_NOISE  = 3'd5,
    FG_DC     = 3'd6
  } fg_func_e;

  // Waveform selected out of reset (DC alias).
  localparam logic [2:0]  FG_RESET_FUNC = 3'b111;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sine_qlut.sv
// sine_qlut: combinational quarter-wave sine magnitude table.
//   a : quarter-wave address (LUT_AW bits)
//   e : magnitude round((2^(DW-1)-1) * sin(pi/2 * (a+0.5) / 2^LUT_AW)), DW-1 bits
// The half-LSB address offset keeps the table symmetric, so mirrored quadrants
// reuse it without a duplicated peak or zero sample.
`timescale 1ns/1ps
module sine_qlut #(
  parameter int DW     = 8,
  parameter int LUT_AW = 6
) (
  input  logic [LUT_AW-1:0] a,
  output logic [DW-2:0]     e
);

  localparam int DEPTH = 2 ** LUT_AW;

  // Elaboration-time sine via a Taylor series; on [0, pi/2] the terms up to
  // x^15 are accurate far below one LSB of a 15-bit magnitude.
  function automatic int sine_entry(input int idx);
    real x;
    real term;
    real sum;
    x    = 1.5707963267948966 * (real'(idx) + 0.5) / real'(DEPTH);
    term = x;
    sum  = x;
    for (int k = 1; k < 8; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    sine_entry = int'(real'((1 << (DW - 1)) - 1) * sum);
  endfunction

  // NOTE: this is a constant ROM, not storage -- it has no reset and needs none.
  logic [DW-2:0] lut_rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_lut
    localparam int V = sine_entry(i);
    assign lut_rom[i] = V[DW-2:0];
  end

  assign e = lut_rom[a];

endmodule

// File: rtl/func_gen_dds.sv
// func_gen_dds: DDS function generator with a PW-bit phase accumulator.
//   clk, rst  : clock; asynchronous active-high reset
//   en        : advance accumulator, LFSR and pipeline; everything holds when low
//   func      : waveform select, adopted only at a phase wrap
//   ftw       : frequency tuning word, added to the phase every enabled cycle
//   amp       : amplitude, 2^DW = unity, larger values clamp to unity
//   out       : offset-binary sample, midscale 2^(DW-1)
//   out_valid : out holds a computed sample
//   wrap      : pulse with the first sample of each new period
// Pipeline: phase -> stage 1 (raw waveform) -> stage 2 (amplitude scaling).
`timescale 1ns/1ps
module func_gen_dds
  import func_gen_pkg::*;
#(
  parameter int DW     = 8,
  parameter int PW     = 16,
  parameter int LUT_AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    func,
  input  logic [PW-1:0] ftw,
  input  logic [DW:0]   amp,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic          wrap
);

  localparam logic [DW-1:0] MID   = {1'b1, {(DW - 1){1'b0}}};
  localparam logic [DW:0]   UNITY = {1'b1, {DW{1'b0}}};
  localparam int            PRW   = 2 * DW + 3;

  // Accumulator and shadowed configuration.
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_sum;
  logic          carry;
  logic          carry_d;
  logic [15:0]   lfsr;
  logic [2:0]    func_act;
  logic [DW:0]   amp_act;
  logic [DW:0]   amp_clamped;
  logic          cfg_loaded;

  // Stage 1.
  logic [DW-1:0] raw_s1;
  logic [DW:0]   amp_s1;
  logic          wrap_s1;
  logic          valid_s1;

  assign {carry, phase_sum} = {1'b0, phase} + {1'b0, ftw};
  assign amp_clamped        = amp[DW] ? UNITY : amp;

  // Sine: the top two phase bits pick the quadrant; odd quadrants run the
  // table backwards, the upper half-period subtracts from midscale.
  logic [1:0]        quad;
  logic [LUT_AW-1:0] sine_addr;
  logic [DW-2:0]     sine_e;
  logic [DW-1:0]     sine_val;

  assign quad      = phase[PW-1 -: 2];
  assign sine_addr = quad[0] ? ~phase[PW-3 -: LUT_AW] : phase[PW-3 -: LUT_AW];
  assign sine_val  = quad[1] ? (MID - {1'b0, sine_e}) : (MID + {1'b0, sine_e});

  sine_qlut #(
    .DW    (DW),
    .LUT_AW(LUT_AW)
  ) u_sine_qlut (
    .a(sine_addr),
    .e(sine_e)
  );

  logic [DW-1:0] p;
  logic [DW-1:0] p_dbl;
  logic [DW-1:0] wave;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wave  = MID;
    p     = phase[PW-1 -: DW];
    p_dbl = {p[DW-2:0], 1'b0};
    case (func_act)
      FG_SQUARE: wave = p[DW-1] ? '0 : '1;
      FG_SINE:   wave = sine_val;
      FG_TRI:    wave = p[DW-1] ? ~p_dbl : p_dbl;
      FG_SAW:    wave = p;
      FG_RSAW:   wave = ~p;
      FG_NOISE:  wave = lfsr[15 -: DW];
      default:   wave = MID;
    endcase
  end

  // Stage 2 scaling: (raw - mid) * amp, floor-shifted by DW. The product of a
  // DW+1-bit signed difference and a non-negative amp (<= 2^DW) always lands
  // in [-mid, mid-1] after the shift, so the low DW bits plus mid are exact.
  logic signed [DW:0]    diff;
  logic signed [PRW-1:0] diff_x;
  logic signed [PRW-1:0] amp_x;
  logic signed [PRW-1:0] prod;
  logic signed [PRW-1:0] scaled;
  logic [DW-1:0]         out_next;
  logic                  scaled_unused;

  assign diff          = signed'({1'b0, raw_s1}) - signed'({1'b0, MID});
  assign diff_x        = PRW'(diff);
  assign amp_x         = signed'({{(DW + 2){1'b0}}, amp_s1});
  assign prod          = diff_x * amp_x;
  assign scaled        = prod >>> DW;
  assign out_next      = MID + scaled[DW-1:0];
  assign scaled_unused = ^scaled[PRW-1:DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      lfsr       <= LFSR_SEED;
      func_act   <= FG_RESET_FUNC;
      amp_act    <= UNITY;
      cfg_loaded <= 1'b0;
      carry_d    <= 1'b0;
      raw_s1     <= MID;
      amp_s1     <= UNITY;
      wrap_s1    <= 1'b0;
      valid_s1   <= 1'b0;
      out        <= MID;
      wrap       <= 1'b0;
      out_valid  <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments, so every stage reads the pre-edge value
      // of the stage before it regardless of statement order.
      phase      <= phase_sum;
      lfsr       <= lfsr_next(lfsr);
      cfg_loaded <= 1'b1;
      // Config changes only at period boundaries, keeping each period whole.
      if (!cfg_loaded || carry) begin
        func_act <= func;
        amp_act  <= amp_clamped;
      end
      // carry marks the phase written this edge as the first of a period; it
      // is sampled into stage 1 one edge later, together with that phase.
      carry_d    <= carry;
      raw_s1     <= wave;
      amp_s1     <= amp_act;
      wrap_s1    <= carry_d;
      valid_s1   <= 1'b1;
      out        <= out_next;
      wrap       <= wrap_s1;
      out_valid  <= valid_s1;
    end
  end

endmodule

// File: tb/tb_func_gen_dds.sv
// tb_func_gen_dds: directed self-checking bench for func_gen_dds (DW=8, PW=16,
// LUT_AW=6). A table of single-point vectors is followed by sequences for
// reset, wrap/period behaviour, enable hold, config switching and noise.
`timescale 1ns/1ps
module tb_func_gen_dds;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  func = 3'd0;
  logic [15:0] ftw = 16'h0000;
  logic [8:0]  amp = 9'd0;
  logic [7:0]  out;
  logic        out_valid;
  logic        wrap;

  int checks = 0;
  int failures = 0;

  func_gen_dds #(
    .DW    (8),
    .PW    (16),
    .LUT_AW(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .func     (func),
    .ftw      (ftw),
    .amp      (amp),
    .out      (out),
    .out_valid(out_valid),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Sine sample for phase j*0x0400 built from the table definition.
  function automatic int ref_sine(input int j);
    int  ph;
    int  q;
    int  a;
    real mag;
    ph  = (j * 1024) % 65536;
    q   = ph >> 14;
    a   = (ph >> 8) & 63;
    if (q == 1 || q == 3) a = 63 - a;
    mag = 127.0 * $sin(1.5707963267948966 * (real'(a) + 0.5) / 64.0);
    return (q < 2) ? 128 + int'(mag) : 128 - int'(mag);
  endfunction

  typedef struct {
    logic [2:0]  func;
    logic [15:0] ftw;
    logic [8:0]  amp;
    int          n;
    int          exp_out;
  } vec_t;

  vec_t vecs [22];

  initial begin
    int samp [64];
    int mx;
    int mn;
    logic [15:0] lf;
    int exp_o;
    int m;

    // Sample after the n-th enabled edge from reset shows phase (n-2)*ftw.
    vecs[0]  = '{3'd0, 16'h1000, 9'd256, 3,  255};  // square p=16
    vecs[1]  = '{3'd0, 16'h1000, 9'd256, 9,  255};  // square p=112
    vecs[2]  = '{3'd0, 16'h1000, 9'd256, 10, 0};    // square p=128 boundary
    vecs[3]  = '{3'd0, 16'h1000, 9'd128, 3,  191};  // half amplitude high
    vecs[4]  = '{3'd0, 16'h1000, 9'd300, 3,  255};  // amp clamps to unity
    vecs[5]  = '{3'd2, 16'h1000, 9'd256, 3,  32};   // triangle rising
    vecs[6]  = '{3'd2, 16'h1000, 9'd256, 10, 255};  // triangle peak p=128
    vecs[7]  = '{3'd2, 16'h1000, 9'd256, 12, 191};  // triangle falling p=160
    vecs[8]  = '{3'd3, 16'h0100, 9'd256, 2,  128};  // first output is DC
    vecs[9]  = '{3'd3, 16'h0100, 9'd256, 50, 48};   // sawtooth
    vecs[10] = '{3'd4, 16'h0100, 9'd256, 50, 207};  // reverse sawtooth
    vecs[11] = '{3'd3, 16'h0100, 9'd0,   50, 128};  // zero amplitude
    vecs[12] = '{3'd3, 16'h0100, 9'd511, 50, 48};   // max amp clamps
    vecs[13] = '{3'd3, 16'h0100, 9'd128, 51, 88};   // -39.5 floors to -40
    vecs[14] = '{3'd6, 16'h0100, 9'd256, 5,  128};  // DC
    vecs[15] = '{3'd7, 16'h0100, 9'd256, 5,  128};  // DC alias
    vecs[16] = '{3'd1, 16'h0400, 9'd256, 10, 219};  // sine phase 0x2000
    vecs[17] = '{3'd1, 16'h0400, 9'd256, 26, 217};  // sine phase 0x6000
    vecs[18] = '{3'd1, 16'h0400, 9'd256, 66, 130};  // sine phase 0 after wrap
    vecs[19] = '{3'd5, 16'h0100, 9'd256, 3,  226};  // noise, 1 shift
    vecs[20] = '{3'd5, 16'h0100, 9'd256, 4,  113};  // noise, 2 shifts
    vecs[21] = '{3'd3, 16'h0000, 9'd256, 5,  0};    // ftw=0 holds phase 0

    // Reset state.
    do_reset();
    check("reset out", int'(out), 128);
    check("reset out_valid", int'(out_valid), 0);
    check("reset wrap", int'(wrap), 0);

    // Table-driven single-point vectors.
    for (int i = 0; i < 22; i++) begin
      do_reset();
      func = vecs[i].func;
      ftw  = vecs[i].ftw;
      amp  = vecs[i].amp;
      en   = 1'b1;
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d out", i), int'(out), vecs[i].exp_out);
      check($sformatf("vec%0d valid", i), int'(out_valid), 1);
    end

    // Sawtooth ramp, wrap only with out=0, enable hold mid-ramp.
    do_reset();
    func = 3'd3; ftw = 16'h0100; amp = 9'd256; en = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 1) begin
        check("saw valid n1", int'(out_valid), 0);
      end else if (n == 2) begin
        check("saw dc n2", int'(out), 128);
        check("saw valid n2", int'(out_valid), 1);
      end else begin
        check($sformatf("saw out n%0d", n), int'(out), (n - 2) % 256);
        check($sformatf("saw wrap n%0d", n), int'(wrap), ((n - 2) % 256 == 0) ? 1 : 0);
      end
      if (n == 100) begin
        en = 1'b0;
        repeat (5) begin
          tick();
          check("hold out", int'(out), 98);
          check("hold wrap", int'(wrap), 0);
          check("hold valid", int'(out_valid), 1);
        end
        en = 1'b1;
      end
    end

    // Asynchronous reset mid-stream while wrap is high.
    do_reset();
    func = 3'd3; ftw = 16'h0100; amp = 9'd256; en = 1'b1;
    repeat (258) tick();
    check("pre-reset wrap", int'(wrap), 1);
    #2 rst = 1'b1;
    #1;
    check("async rst out", int'(out), 128);
    check("async rst valid", int'(out_valid), 0);
    check("async rst wrap", int'(wrap), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post-rst valid e1", int'(out_valid), 0);
    tick();
    check("post-rst valid e2", int'(out_valid), 1);
    check("post-rst out e2", int'(out), 128);

    // Half-amplitude square: 8 x 191, 8 x 64, wrap on the first 191.
    do_reset();
    func = 3'd0; ftw = 16'h1000; amp = 9'd128; en = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (n >= 3) begin
        check($sformatf("sq out n%0d", n), int'(out), (((n - 2) % 16) < 8) ? 191 : 64);
        check($sformatf("sq wrap n%0d", n), int'(wrap), (n >= 18 && (n - 2) % 16 == 0) ? 1 : 0);
      end
    end

    // Sine: 64-sample period, extremes and half-period symmetry.
    do_reset();
    func = 3'd1; ftw = 16'h0400; amp = 9'd256; en = 1'b1;
    tick();
    tick();
    mx = 0;
    mn = 255;
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (k <= 64) begin
        samp[k % 64] = int'(out);
        if (int'(out) > mx) mx = int'(out);
        if (int'(out) < mn) mn = int'(out);
        check($sformatf("sine ref j%0d", k % 64), int'(out), ref_sine(k));
      end else begin
        check($sformatf("sine period j%0d", k % 64), int'(out), samp[k % 64]);
      end
    end
    check("sine max", mx, 255);
    check("sine min", mn, 1);
    for (int i = 0; i < 32; i++)
      check($sformatf("sine sym i%0d", i), samp[i] + samp[i + 32], 256);

    // Mid-period switch saw -> half-amplitude triangle, applied at the wrap.
    do_reset();
    func = 3'd3; ftw = 16'h0100; amp = 9'd256; en = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n >= 3 && n <= 257) begin
        check($sformatf("sw saw n%0d", n), int'(out), n - 2);
      end else if (n >= 258) begin
        int p;
        int raw;
        p   = (n - 2) % 256;
        raw = (p < 128) ? 2 * p : 255 - ((2 * p) % 256);
        check($sformatf("sw tri n%0d", n), int'(out), 128 + ((raw - 128) >>> 1));
        check($sformatf("sw wrap n%0d", n), int'(wrap), (n == 258) ? 1 : 0);
      end
      if (n == 102) begin
        check("sw trigger", int'(out), 100);
        func = 3'd2;
        amp  = 9'd128;
      end
      if (n == 258) check("sw first tri", int'(out), 64);
      if (n == 385) check("sw tri peak", int'(out), 191);
    end

    // Noise with random enable: LFSR steps only on enabled edges.
    do_reset();
    func = 3'd5; ftw = 16'h0100; amp = 9'd256;
    lf = 16'hACE1;
    exp_o = 128;
    m = 0;
    for (int i = 0; i < 200; i++) begin
      en = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      if (en) begin
        m++;
        if (m >= 3) begin
          lf = ref_lfsr(lf);
          exp_o = int'(lf[15:8]);
        end
      end
      check($sformatf("noise i%0d", i), int'(out), exp_o);
      check($sformatf("noise valid i%0d", i), int'(out_valid), (m >= 2) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
